// File: rtl/tl_ram_arbiter_pkg.sv
// Shared TileLink-UL types for the two-requester RAM arbiter: channel structs,
// opcodes, requester count and owner-index type.
package tl_ram_arbiter_pkg;

  localparam int unsigned TL_NUM_REQ = 2;

  typedef logic [$clog2(TL_NUM_REQ)-1:0] tl_owner_idx_t;

  localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic          a_valid;
    logic [2:0]    a_opcode;
    logic [1:0]    a_size;
    tl_owner_idx_t a_source;
    logic [31:0]   a_address;
    logic [3:0]    a_mask;
    logic [31:0]   a_data;
    logic          d_ready;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic        d_error;
    logic [31:0] d_data;
    logic        d_ready;
  } tilelink_d;

endpackage

// File: rtl/tl_ram_arbiter_arb_rr2.sv
// Two-way grant selector. Round-robin by default; defining
// TL_RAM_ARB_FIXED_PRIORITY_EN makes requester 0 always win contention.
module arb_rr2
  import tl_ram_arbiter_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [TL_NUM_REQ-1:0] req,
  output logic [TL_NUM_REQ-1:0] gnt
);

`ifdef TL_RAM_ARB_FIXED_PRIORITY_EN
  logic unused_clock;
  assign unused_clock = clock;

  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (req[0]) gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end
`else
  typedef enum logic {PRIO_REQ0, PRIO_REQ1} prio_e;

  prio_e prio_q, prio_d;

  always_ff @(posedge clock) begin
    if (reset) prio_q <= PRIO_REQ0;
    else       prio_q <= prio_d;
  end

  always_comb begin
    gnt    = '0;
    prio_d = prio_q;
    if (!reset) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (prio_q == PRIO_REQ0) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
      // Pointer moves only on a grant, toward the requester just passed over.
      if (gnt[0])      prio_d = PRIO_REQ1;
      else if (gnt[1]) prio_d = PRIO_REQ0;
    end
  end
`endif

endmodule

// File: rtl/tl_ram_arbiter.sv
// Shares one 1-cycle-latency block RAM between two TileLink requesters; decodes
// the RAM window, answers misses locally with an error. Honours TL_RAM_ARB_FIXED_PRIORITY_EN.
module tl_ram_arbiter
  import tl_ram_arbiter_pkg::*;
#(
  parameter logic [31:0] addr_mask = 32'hF0000000,
  parameter logic [31:0] addr_tag  = 32'h00000000
) (
  input  logic      clock,
  input  logic      reset,
  input  tilelink_a tla0,
  output tilelink_d tld0,
  input  tilelink_a tla1,
  output tilelink_d tld1,
  output tilelink_a ram_tla,
  input  tilelink_d ram_tld
);

  logic [TL_NUM_REQ-1:0] req;
  logic [TL_NUM_REQ-1:0] gnt;
  tilelink_a             acc_a;
  tl_owner_idx_t         acc_idx;
  logic                  accepted;
  logic                  hit;

  logic                  own_valid_q, own_valid_d;
  tl_owner_idx_t         own_idx_q, own_idx_d;
  logic                  own_err_q, own_err_d;
  tilelink_d             rsp;

  assign req = {tla1.a_valid, tla0.a_valid};

  arb_rr2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  always_comb begin
    accepted = |gnt;
    acc_idx  = tl_owner_idx_t'(gnt[1]);
    acc_a    = gnt[1] ? tla1 : tla0;
    hit      = ((acc_a.a_address & addr_mask) == addr_tag);

    ram_tla         = '0;
    ram_tla.d_ready = 1'b1;
    if (accepted && hit) begin
      ram_tla          = acc_a;
      ram_tla.a_source = acc_idx;
      ram_tla.d_ready  = 1'b1;
    end

    own_valid_d = accepted;
    own_idx_d   = acc_idx;
    own_err_d   = accepted && !hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      own_valid_q <= 1'b0;
      own_idx_q   <= '0;
      own_err_q   <= 1'b0;
    end else begin
      own_valid_q <= own_valid_d;
      own_idx_q   <= own_idx_d;
      own_err_q   <= own_err_d;
    end
  end

  // Decode misses never reached the RAM, so the error beat is synthesised here.
  always_comb begin
    rsp = '0;
    if (own_valid_q && !reset) begin
      rsp.d_valid = 1'b1;
      if (own_err_q) begin
        rsp.d_opcode = TL_D_ACCESS_ACK_DATA;
        rsp.d_error  = 1'b1;
      end else begin
        rsp.d_opcode = ram_tld.d_opcode;
        rsp.d_error  = ram_tld.d_error;
        rsp.d_data   = ram_tld.d_data;
      end
    end

    tld0 = '0;
    tld1 = '0;
    if (own_idx_q == '0) tld0 = rsp;
    else                 tld1 = rsp;
    tld0.d_ready = gnt[0];
    tld1.d_ready = gnt[1];
  end

  logic unused_bits;
  assign unused_bits = ^{tla0.a_source, tla0.d_ready, tla1.a_source, tla1.d_ready,
                         ram_tld.d_valid, ram_tld.d_ready};

endmodule

// File: tb/tb_tl_ram_arbiter.sv
// Bench for tl_ram_arbiter: behavioural RAM device plus a transaction-level
// reference model (pending beats, last-winner pointer, word memory).
module tb_tl_ram_arbiter;
  import tl_ram_arbiter_pkg::*;

`ifdef TL_RAM_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic      clock = 1'b0;
  logic      reset = 1'b1;
  tilelink_a tla0, tla1, ram_tla;
  tilelink_d tld0, tld1, ram_tld;

  tl_ram_arbiter #(
    .addr_mask (32'hF0000000),
    .addr_tag  (32'h00000000)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .tla0    (tla0),
    .tld0    (tld0),
    .tla1    (tla1),
    .tld1    (tld1),
    .ram_tla (ram_tla),
    .ram_tld (ram_tld)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  // Block RAM device: registered response one cycle after the request.
  logic [31:0] ram_mem [0:255];
  bit          ram_written [0:255];
  bit          spur = 1'b0;

  always @(posedge clock) begin
    ram_tld.d_valid <= ram_tla.a_valid | spur;
    ram_tld.d_ready <= 1'b1;
    ram_tld.d_error <= !ram_tla.a_valid && spur;
    if (ram_tla.a_valid && ram_tla.a_opcode == TL_A_GET) begin
      ram_tld.d_opcode <= TL_D_ACCESS_ACK_DATA;
      ram_tld.d_data   <= ram_written[ram_tla.a_address[9:2]] ? ram_mem[ram_tla.a_address[9:2]]
                                                              : (32'hC0DE0000 | 32'(ram_tla.a_address[9:2]));
    end else if (ram_tla.a_valid) begin
      ram_tld.d_opcode <= TL_D_ACCESS_ACK;
      ram_tld.d_data   <= '0;
      if (!ram_written[ram_tla.a_address[9:2]]) begin
        ram_written[ram_tla.a_address[9:2]] <= 1'b1;
        for (int b = 0; b < 4; b++)
          ram_mem[ram_tla.a_address[9:2]][8*b +: 8] <= ram_tla.a_mask[b] ? ram_tla.a_data[8*b +: 8]
                                                      : 8'((32'hC0DE0000 | 32'(ram_tla.a_address[9:2])) >> (8*b));
      end else begin
        for (int b = 0; b < 4; b++)
          if (ram_tla.a_mask[b]) ram_mem[ram_tla.a_address[9:2]][8*b +: 8] <= ram_tla.a_data[8*b +: 8];
      end
    end else begin
      ram_tld.d_opcode <= TL_D_ACCESS_ACK_DATA;
      ram_tld.d_data   <= 32'hBAD0BAD0;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:255];
  bit          p_valid [2];
  logic [2:0]  p_op    [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_data  [2];
  logic [3:0]  p_mask  [2];
  int          last_gnt;
  bit          nx_valid;
  int          nx_idx;
  logic [31:0] nx_data;
  logic        nx_err;
  logic [2:0]  nx_op;
  bit          cur_rst;

  // Expectations for the cycle currently being driven.
  int          exp_gnt;
  bit          exp_dv [2];
  logic [31:0] exp_data;
  logic        exp_err;
  logic [2:0]  exp_op;
  bit          exp_ram_v;

  function automatic tilelink_a mk(input int i);
    tilelink_a t;
    t           = '0;
    t.a_valid   = p_valid[i];
    t.a_opcode  = p_op[i];
    t.a_size    = 2'd2;
    t.a_source  = tl_owner_idx_t'($urandom);
    t.a_address = p_addr[i];
    t.a_mask    = p_mask[i];
    t.a_data    = p_data[i];
    t.d_ready   = 1'($urandom);
    return t;
  endfunction

  task automatic set_beat(input int i, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] mask);
    p_valid[i] = 1'b1;
    p_op[i]    = op;
    p_addr[i]  = addr;
    p_data[i]  = data;
    p_mask[i]  = mask;
  endtask

  task automatic drive_cycle(input bit rst_val);
    @(negedge clock);
    reset   = rst_val;
    cur_rst = rst_val;
    tla0    = mk(0);
    tla1    = mk(1);
    #1;
    for (int i = 0; i < 2; i++) exp_dv[i] = !rst_val && nx_valid && (nx_idx == i);
    exp_data = nx_data;
    exp_err  = nx_err;
    exp_op   = nx_op;
    exp_gnt  = -1;
    if (!rst_val) begin
      if (p_valid[0] && p_valid[1]) exp_gnt = FIXED ? 0 : ((last_gnt == 0) ? 1 : 0);
      else if (p_valid[0])          exp_gnt = 0;
      else if (p_valid[1])          exp_gnt = 1;
    end
    exp_ram_v = (exp_gnt >= 0) && (p_addr[exp_gnt] < 32'h10000000);
  endtask

  task automatic commit_cycle();
    int g;
    int w;
    nx_valid = 1'b0;
    if (cur_rst) begin
      last_gnt = 1;
    end else if (exp_gnt >= 0) begin
      g        = exp_gnt;
      w        = int'(p_addr[g][9:2]);
      nx_valid = 1'b1;
      nx_idx   = g;
      last_gnt = g;
      if (!exp_ram_v) begin
        nx_err = 1'b1; nx_op = TL_D_ACCESS_ACK_DATA; nx_data = '0;
      end else if (p_op[g] == TL_A_GET) begin
        nx_err = 1'b0; nx_op = TL_D_ACCESS_ACK_DATA; nx_data = ref_mem[w];
      end else begin
        nx_err = 1'b0; nx_op = TL_D_ACCESS_ACK; nx_data = '0;
        for (int b = 0; b < 4; b++)
          if (p_mask[g][b]) ref_mem[w][8*b +: 8] = p_data[g][8*b +: 8];
      end
      p_valid[g] = 1'b0;
    end
    @(posedge clock);
  endtask

  task automatic test_reset();
    set_beat(0, TL_A_GET, 32'h0, '0, 4'hF);
    set_beat(1, TL_A_GET, 32'h4, '0, 4'hF);
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b1);
      nvec++; if (tld0.d_ready !== 1'b0) begin nerr++; $display("FAIL rst_rdy0: got %b want 0", tld0.d_ready); end
      nvec++; if (tld1.d_ready !== 1'b0) begin nerr++; $display("FAIL rst_rdy1: got %b want 0", tld1.d_ready); end
      nvec++; if (ram_tla.a_valid !== 1'b0) begin nerr++; $display("FAIL rst_ram_v: got %b want 0", ram_tla.a_valid); end
      nvec++; if ({tld0.d_valid, tld1.d_valid, tld0.d_error, tld1.d_error} !== 4'b0000)
        begin nerr++; $display("FAIL rst_d: got %b want 0000", {tld0.d_valid, tld1.d_valid, tld0.d_error, tld1.d_error}); end
      commit_cycle();
    end
    p_valid[0] = 1'b0;
    p_valid[1] = 1'b0;
  endtask

  task automatic test_single_read();
    set_beat(0, TL_A_GET, 32'h00000010, '0, 4'hF);
    drive_cycle(1'b0);
    nvec++; if ({tld0.d_ready, tld1.d_ready} !== 2'b10) begin nerr++; $display("FAIL single_rdy: got %b want 10", {tld0.d_ready, tld1.d_ready}); end
    nvec++; if (ram_tla.a_valid !== 1'b1 || ram_tla.a_address !== 32'h10 || ram_tla.a_source !== 1'b0)
      begin nerr++; $display("FAIL single_ram: got v=%b a=%h s=%b want 1/10/0", ram_tla.a_valid, ram_tla.a_address, ram_tla.a_source); end
    commit_cycle();
    drive_cycle(1'b0);
    nvec++; if (tld0.d_valid !== 1'b1 || tld0.d_data !== ref_mem[4] || tld0.d_error !== 1'b0)
      begin nerr++; $display("FAIL single_rsp: got v=%b d=%h want 1/%h", tld0.d_valid, tld0.d_data, ref_mem[4]); end
    nvec++; if (tld1.d_valid !== 1'b0) begin nerr++; $display("FAIL single_rsp1: got %b want 0", tld1.d_valid); end
    commit_cycle();
  endtask

  task automatic test_contention();
    int want, prev;
    drive_cycle(1'b1);
    commit_cycle();
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      if (!p_valid[0]) set_beat(0, TL_A_GET, 32'h0, '0, 4'hF);
      if (!p_valid[1]) set_beat(1, TL_A_GET, 32'h4, '0, 4'hF);
      drive_cycle(1'b0);
      want = FIXED ? 0 : (k % 2);
      nvec++; if ({tld1.d_ready, tld0.d_ready} !== ((want == 0) ? 2'b01 : 2'b10))
        begin nerr++; $display("FAIL contend_gnt[%0d]: got %b want idx %0d", k, {tld1.d_ready, tld0.d_ready}, want); end
      if (prev >= 0) begin
        nvec++; if ({tld1.d_valid, tld0.d_valid} !== ((prev == 0) ? 2'b01 : 2'b10))
          begin nerr++; $display("FAIL contend_owner[%0d]: got %b want idx %0d", k, {tld1.d_valid, tld0.d_valid}, prev); end
        nvec++; if (((prev == 0) ? tld0.d_data : tld1.d_data) !== ref_mem[prev])
          begin nerr++; $display("FAIL contend_data[%0d]: got %h want %h", k, (prev == 0) ? tld0.d_data : tld1.d_data, ref_mem[prev]); end
      end
      prev = want;
      commit_cycle();
    end
    p_valid[0] = 1'b0;
    p_valid[1] = 1'b0;
    drive_cycle(1'b0);
    commit_cycle();
  endtask

  task automatic test_put_then_get();
    set_beat(1, TL_A_PUT_FULL, 32'h00000020, 32'hDEADBEEF, 4'hF);
    drive_cycle(1'b0);
    nvec++; if (tld1.d_ready !== 1'b1 || ram_tla.a_source !== 1'b1)
      begin nerr++; $display("FAIL put_gnt: got rdy=%b src=%b want 1/1", tld1.d_ready, ram_tla.a_source); end
    commit_cycle();
    set_beat(0, TL_A_GET, 32'h00000020, '0, 4'hF);
    drive_cycle(1'b0);
    nvec++; if (tld1.d_valid !== 1'b1 || tld1.d_opcode !== TL_D_ACCESS_ACK)
      begin nerr++; $display("FAIL put_ack: got v=%b op=%0d want 1/0", tld1.d_valid, tld1.d_opcode); end
    commit_cycle();
    drive_cycle(1'b0);
    nvec++; if (tld0.d_valid !== 1'b1 || tld0.d_data !== 32'hDEADBEEF)
      begin nerr++; $display("FAIL put_get: got v=%b d=%h want 1/deadbeef", tld0.d_valid, tld0.d_data); end
    commit_cycle();
  endtask

  task automatic test_decode_miss();
    set_beat(1, TL_A_GET, 32'h10000000, '0, 4'hF);
    drive_cycle(1'b0);
    nvec++; if (tld1.d_ready !== 1'b1 || ram_tla.a_valid !== 1'b0)
      begin nerr++; $display("FAIL miss_req: got rdy=%b ram_v=%b want 1/0", tld1.d_ready, ram_tla.a_valid); end
    commit_cycle();
    drive_cycle(1'b0);
    nvec++; if ({tld1.d_valid, tld1.d_error, tld1.d_data, tld1.d_opcode} !== {1'b1, 1'b1, 32'h0, TL_D_ACCESS_ACK_DATA})
      begin nerr++; $display("FAIL miss_rsp: got v=%b e=%b d=%h op=%0d want 1/1/0/1", tld1.d_valid, tld1.d_error, tld1.d_data, tld1.d_opcode); end
    nvec++; if (tld0.d_valid !== 1'b0) begin nerr++; $display("FAIL miss_rsp0: got %b want 0", tld0.d_valid); end
    commit_cycle();
  endtask

  task automatic test_spurious();
    drive_cycle(1'b0);
    spur = 1'b1;
    commit_cycle();
    drive_cycle(1'b0);
    spur = 1'b0;
    nvec++; if ({tld0.d_valid, tld1.d_valid} !== 2'b00)
      begin nerr++; $display("FAIL spurious: got %b want 00", {tld0.d_valid, tld1.d_valid}); end
    commit_cycle();
    set_beat(0, TL_A_GET, 32'h00000010, '0, 4'hF);
    drive_cycle(1'b0);
    commit_cycle();
    drive_cycle(1'b0);
    nvec++; if (tld0.d_valid !== 1'b1 || tld0.d_error !== 1'b0 || tld0.d_data !== ref_mem[4])
      begin nerr++; $display("FAIL spur_after: got v=%b e=%b d=%h want 1/0/%h", tld0.d_valid, tld0.d_error, tld0.d_data, ref_mem[4]); end
    commit_cycle();
  endtask

  task automatic test_reset_mid();
    set_beat(0, TL_A_GET, 32'h00000008, '0, 4'hF);
    drive_cycle(1'b0);
    nvec++; if (tld0.d_ready !== 1'b1) begin nerr++; $display("FAIL rmid_gnt: got %b want 1", tld0.d_ready); end
    commit_cycle();
    drive_cycle(1'b1);
    nvec++; if ({tld0.d_valid, tld1.d_valid} !== 2'b00)
      begin nerr++; $display("FAIL rmid_suppress: got %b want 00", {tld0.d_valid, tld1.d_valid}); end
    commit_cycle();
    set_beat(0, TL_A_GET, 32'h0, '0, 4'hF);
    set_beat(1, TL_A_GET, 32'h4, '0, 4'hF);
    drive_cycle(1'b0);
    nvec++; if ({tld0.d_valid, tld1.d_valid} !== 2'b00)
      begin nerr++; $display("FAIL rmid_after: got %b want 00", {tld0.d_valid, tld1.d_valid}); end
    nvec++; if ({tld0.d_ready, tld1.d_ready} !== 2'b10)
      begin nerr++; $display("FAIL rmid_first: got %b want 10", {tld0.d_ready, tld1.d_ready}); end
    commit_cycle();
  endtask

  task automatic test_back_to_back();
    tilelink_d   d;
    logic [31:0] a;
    logic [3:0]  m;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_valid[i] && $urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 4) == 0) a = {4'($urandom_range(1, 15)), 28'($urandom_range(0, 4095))};
          else                           a = 32'($urandom_range(0, 15)) << 2;
          m = 4'($urandom_range(1, 15));
          if ($urandom_range(0, 1) == 0) set_beat(i, TL_A_GET, a, '0, 4'hF);
          else set_beat(i, (m == 4'hF) ? TL_A_PUT_FULL : TL_A_PUT_PARTIAL, a, $urandom, m);
        end
      end
      drive_cycle(1'b0);
      nvec++; if ({tld1.d_ready, tld0.d_ready} !== {exp_gnt == 1, exp_gnt == 0})
        begin nerr++; $display("FAIL b2b_gnt[%0d]: got %b want idx %0d", k, {tld1.d_ready, tld0.d_ready}, exp_gnt); end
      nvec++; if (ram_tla.a_valid !== exp_ram_v)
        begin nerr++; $display("FAIL b2b_ram_v[%0d]: got %b want %b", k, ram_tla.a_valid, exp_ram_v); end
      if (exp_ram_v) begin
        nvec++; if (ram_tla.a_source !== tl_owner_idx_t'(exp_gnt) || ram_tla.a_address !== p_addr[exp_gnt] || ram_tla.a_opcode !== p_op[exp_gnt])
          begin nerr++; $display("FAIL b2b_ram_a[%0d]: got s=%b a=%h op=%0d want s=%0d a=%h op=%0d", k, ram_tla.a_source,
                                 ram_tla.a_address, ram_tla.a_opcode, exp_gnt, p_addr[exp_gnt], p_op[exp_gnt]); end
      end
      for (int i = 0; i < 2; i++) begin
        d = (i == 0) ? tld0 : tld1;
        nvec++; if (d.d_valid !== exp_dv[i])
          begin nerr++; $display("FAIL b2b_dv%0d[%0d]: got %b want %b", i, k, d.d_valid, exp_dv[i]); end
        if (exp_dv[i]) begin
          nvec++; if ({d.d_opcode, d.d_error, d.d_data} !== {exp_op, exp_err, exp_data})
            begin nerr++; $display("FAIL b2b_d%0d[%0d]: got op=%0d e=%b d=%h want op=%0d e=%b d=%h", i, k,
                                   d.d_opcode, d.d_error, d.d_data, exp_op, exp_err, exp_data); end
        end
      end
      commit_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE0000 | 32'(i);
    for (int i = 0; i < 2; i++) begin
      p_valid[i] = 1'b0; p_op[i] = TL_A_GET; p_addr[i] = '0; p_data[i] = '0; p_mask[i] = 4'hF;
    end
    last_gnt = 1;
    nx_valid = 1'b0;
    nx_idx   = 0;
    nx_data  = '0;
    nx_err   = 1'b0;
    nx_op    = TL_D_ACCESS_ACK;
    tla0     = '0;
    tla1     = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_put_then_get();
    test_decode_miss();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
